// File: rtl/seg7_scroll_driver.sv
// seg7_scroll_driver: multiplexed 7-segment text display with a writable message buffer and optional scrolling.
module seg7_scroll_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_LEN       = 16,
  parameter int SCAN_DIV      = 1000,
  parameter int BLANK_CYC     = 2,
  parameter int SCROLL_FRAMES = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr_i,
  input  logic [3:0]                   wr_data_i,
  input  logic [$clog2(MSG_LEN):0]     msg_len_i,
  input  logic                         scroll_en_i,
  input  logic                         restart_i,
  output logic [6:0]                   segments_o,
  output logic [NUM_DIGITS-1:0]        dig_en_o,
  output logic                         wrap_o
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = SCROLL_FRAMES > 1 ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1110111, 7'b1111100, 7'b1011110, 7'b0111110,
    7'b0111000, 7'b1000000, 7'b0001110, 7'b0111111,
    7'b1101101, 7'b1111001, 7'b0111001, 7'b1110110,
    7'b1110011, 7'b1010100, 7'b1111000, 7'b0000000
  };

  logic [3:0]            msg_q [MSG_LEN];
  logic [PW-1:0]         presc_q, presc_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [AW-1:0]         off_q, off_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic                  wrap_q, wrap_d;
  logic [LW-1:0]         len, p_sum, p;
  logic                  presc_wrap, frame_end, step, active, blank;

  always_comb begin
    len        = (msg_len_i == '0 || msg_len_i > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len_i;
    presc_wrap = presc_q == PW'(SCAN_DIV - 1);
    frame_end  = presc_wrap && dig_q == DW'(NUM_DIGITS - 1);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    dig_d      = !presc_wrap ? dig_q : frame_end ? '0 : dig_q + 1'b1;
    step       = scroll_en_i && frame_end && frame_q == FW'(SCROLL_FRAMES - 1);
    frame_d    = (restart_i || !scroll_en_i || step) ? '0 : frame_end ? frame_q + 1'b1 : frame_q;
    // A shrunken length that strands the offset snaps it home without a wrap pulse
    off_d      = (restart_i || LW'(off_q) >= len) ? '0 :
                 !step ? off_q : (LW'(off_q) + 1'b1 == len) ? '0 : off_q + 1'b1;
    wrap_d     = !restart_i && LW'(off_q) < len && step && LW'(off_q) + 1'b1 == len;
    active     = presc_q >= PW'(BLANK_CYC);
    p_sum      = LW'(off_q) + LW'(dig_q);
    p          = p_sum >= len ? p_sum - len : p_sum;
    blank      = LW'(dig_q) >= len || p >= LW'(MSG_LEN);
    seg_d      = (active && !blank) ? SEG_LUT[msg_q[p[AW-1:0]]] : '0;
    den_d      = active ? NUM_DIGITS'(1) << dig_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MSG_LEN; k++) msg_q[k] <= 4'hf;
      presc_q <= '0;
      dig_q   <= '0;
      frame_q <= '0;
      off_q   <= '0;
      seg_q   <= '0;
      den_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      if (wr_en_i && LW'(wr_addr_i) < LW'(MSG_LEN)) msg_q[wr_addr_i] <= wr_data_i;
      presc_q <= presc_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
      off_q   <= off_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
      wrap_q  <= wrap_d;
    end
  end

  assign segments_o = seg_q;
  assign dig_en_o   = den_q;
  assign wrap_o     = wrap_q;
endmodule

// File: tb/tb_seg7_scroll_driver.sv
// tb_seg7_scroll_driver: directed checks of decode, scan order, scrolling, length shrink, restart and write latency.
module tb_seg7_scroll_driver;
  localparam logic [6:0] SEG [16] = '{
    7'b1110111, 7'b1111100, 7'b1011110, 7'b0111110,
    7'b0111000, 7'b1000000, 7'b0001110, 7'b0111111,
    7'b1101101, 7'b1111001, 7'b0111001, 7'b1110110,
    7'b1110011, 7'b1010100, 7'b1111000, 7'b0000000
  };
  localparam logic [6:0] S_ = 7'b1101101, O_ = 7'b0111111, L_ = 7'b0111000;
  localparam logic [6:0] E_ = 7'b1111001, D_ = 7'b1000000, H_ = 7'b1110110;

  logic       clk = 0, rst = 1, wr_en = 0, scroll_en = 0, restart = 0;
  logic [3:0] wr_addr = 0, wr_data = 0;
  logic [4:0] msg_len = 0;
  logic [6:0] segments;
  logic [3:0] dig_en;
  logic       wrap;
  int         cyc = 0, n_chk = 0, n_pass = 0;

  seg7_scroll_driver #(
    .NUM_DIGITS(4), .MSG_LEN(16), .SCAN_DIV(8), .BLANK_CYC(2), .SCROLL_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .msg_len_i(msg_len), .scroll_en_i(scroll_en), .restart_i(restart),
    .segments_o(segments), .dig_en_o(dig_en), .wrap_o(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wr(input int k, input logic [3:0] a, input logic [3:0] d);
    at(k);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  task automatic disp(input string tag, input int k, input logic [3:0] den, input logic [6:0] seg);
    at(k);
    check({tag, "_den"}, dig_en, den);
    check({tag, "_seg"}, segments, seg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    do_reset(2);
    wr(0, 0, 0);
    disp("pre_rst", 5, 4'b0001, SEG[0]);
    at(20);
    rst = 1;
    @(negedge clk);
    check("rst_seg", segments, 0);
    check("rst_den", dig_en, 0);
    check("rst_wrap", wrap, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) disp("rst_blank", 5 + 8 * i, 4'(1 << i), 7'b0);
    for (int c = 0; c < 16; c++) begin
      wr(32 * (c + 1), 0, 4'(c));
      if (c == 0) disp("blank_slot", 34, 4'b0000, 7'b0);
      disp("decode", 32 * (c + 1) + 5, 4'b0001, SEG[c]);
    end
    for (int j = 0; j < 4; j++) wr(544 + j, 4'(j), 4'(j));
    disp("scan_blank", 577, 4'b0000, 7'b0);
    for (int j = 0; j < 4; j++) disp("scan", 581 + 8 * j, 4'(1 << j), SEG[j]);
    disp("scan_rpt", 613, 4'b0001, SEG[0]);

    do_reset(2);
    msg_len = 5; scroll_en = 1;
    wr(0, 0, 8); wr(1, 1, 7); wr(2, 2, 4); wr(3, 3, 9); wr(4, 4, 5);
    disp("off0", 37, 4'b0001, S_);
    disp("off1", 69, 4'b0001, O_);
    disp("off2", 133, 4'b0001, L_);
    disp("off3", 197, 4'b0001, E_);
    disp("off4_d0", 261, 4'b0001, D_);
    disp("off4_d1", 269, 4'b0010, S_);
    disp("off4_d2", 277, 4'b0100, O_);
    disp("off4_d3", 285, 4'b1000, L_);
    at(319); check("wrap_pre", wrap, 0);
    at(320); check("wrap_hi", wrap, 1);
    at(321); check("wrap_post", wrap, 0);
    disp("off_wrapped", 325, 4'b0001, S_);

    at(580); msg_len = 3;
    at(581); check("shrink_wrap", wrap, 0);
    at(582); check("shrink_wrap2", wrap, 0);
    disp("shrink_d3", 603, 4'b1000, 7'b0);
    disp("shrink_d0", 613, 4'b0001, S_);
    disp("shrink_d1", 621, 4'b0010, O_);
    disp("shrink_d2", 629, 4'b0100, L_);

    at(703); restart = 1;
    @(negedge clk); restart = 0;
    check("restart_wrap", wrap, 0);
    disp("restart_off", 709, 4'b0001, S_);
    at(895); restart = 1;
    @(negedge clk); restart = 0;
    check("restart_wrap_edge", wrap, 0);
    at(897); check("restart_wrap_next", wrap, 0);
    disp("restart_off2", 901, 4'b0001, S_);

    wr(940, 1, 11);
    disp("wr_old", 941, 4'b0010, O_);
    disp("wr_new", 942, 4'b0010, H_);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_scroll_driver.md
Name: seg7_scroll_driver

Overview:
- Multi-digit, time-multiplexed 7-segment text display driver.
- Holds a writable message of 4-bit letter codes and decodes each code to segments.
- Scans NUM_DIGITS common-enable lines and, optionally, scrolls the message across the digits.
- Sits between the control logic (which writes the message) and the board's segment/digit pins.

Parameters:
- NUM_DIGITS, 4: physical digits. Range 1..MSG_LEN.
- MSG_LEN, 16: message buffer depth in characters. Range 2..16.
- SCAN_DIV, 1000: clk cycles per digit slot. Must be ≥ BLANK_CYC+1.
- BLANK_CYC, 2: cycles at the start of each slot with all digit enables low (anti-ghosting).
- SCROLL_FRAMES, 50: full scan frames per scroll step.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one message character this cycle
- wr_addr  in  $clog2(MSG_LEN)  character index to write; ignored if ≥ MSG_LEN
- wr_data  in  4  letter code
- msg_len  in  $clog2(MSG_LEN)+1  active message length; 0 or >MSG_LEN means MSG_LEN
- scroll_en  in  1  1 = scroll, 0 = static (offset held)
- restart  in  1  pulse: offset←0, frame count←0
- segments  out  7  bit0=a … bit6=g, active-high, registered
- dig_en  out  NUM_DIGITS  one-hot active-high digit enable; bit0 = leftmost; registered
- wrap  out  1  one-cycle pulse when scroll offset wraps to 0

Behaviour:
- Letter code table (segments {g,f,e,d,c,b,a}):
  - 0 A=1110111, 1 B=1111100, 2 D=1011110, 3 U=0111110, 4 L=0111000
  - 5 '-'=1000000, 6 J=0001110, 7 O=0111111, 8 S=1101101, 9 E=1111001
  - 10 C=0111001, 11 H=1110110, 12 P=1110011, 13 n=1010100, 14 t=1111000, 15 blank=0000000
- Reset (clk edge with rst=1):
  - All buffer entries ← 15 (blank).
  - Prescaler, digit index, frame count, offset ← 0.
  - segments=0, dig_en=0, wrap=0.
  - Reset asserted mid-operation aborts everything at the next edge.
- Effective length: L = msg_len when 1..MSG_LEN, else MSG_LEN.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the digit index advances i→i+1; NUM_DIGITS-1→0 ends a frame.
- Display outputs (registered, one cycle after the state they reflect):
  - While prescaler < BLANK_CYC: dig_en=0, segments=0.
  - Otherwise: dig_en = one-hot(i), segments = decode(buf[p]), where p = offset+i, minus L if offset+i ≥ L.
  - A digit with i ≥ L shows blank (segments=0, dig_en still one-hot).
- Scroll:
  - With scroll_en=1, the frame counter increments at each frame end.
  - When the counter reaches SCROLL_FRAMES-1 at a frame end, it clears and offset ← offset+1.
  - If offset+1 == L, offset ← 0 instead, and wrap pulses high for exactly one cycle.
  - With scroll_en=0: offset holds, frame counter held at 0, wrap=0.
- Length change: if offset ≥ L in any cycle (msg_len reduced), offset ← 0 on the next edge, with no wrap pulse.
- restart:
  - offset ← 0 and frame counter ← 0 next edge.
  - Has priority over a coincident scroll step; wrap stays 0.
  - Scan prescaler and digit index are unaffected.
- Writes:
  - buf[wr_addr] ← wr_data at the edge.
  - A displayed character reflects the new value from the following cycle's computation, so it appears on segments 2 cycles after wr_en.
  - Writes never stall or disturb scanning.
- Simultaneous events: write, scroll step and digit advance in the same cycle are independent. The display uses pre-edge buffer contents that cycle.
- Widths: all counters are unsigned, sized by $clog2 of their range, and wrap only as specified, never by overflow.

Test Plan:
- Reset: hold rst 3 cycles mid-scan → segments=0, dig_en=0, wrap=0; the buffer then reads as blank on all digits.
- Decode sweep: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, write codes 0..15 to addr 0, static mode → digit 0 shows each table value. Each digit slot is 2 blank cycles followed by 6 active cycles, with dig_en=0001.
- Scan order: write "ABDU" (0,1,2,3) → dig_en sequence 0001, 0010, 0100, 1000, repeating every 32 cycles. Segments are 1110111, 1111100, 1011110, 0111110 in that order.
- Scroll/wrap: msg_len=5, buffer "SOLE-", SCROLL_FRAMES=2, scroll_en=1:
  - Offset steps 1,2,3,4,0 every 64 cycles.
  - Digit 0 shows O after the first step.
  - At offset 4 the digits show "-SOL".
  - wrap is high for 1 cycle at the 4→0 transition.
- Length shrink: at offset=4 drive msg_len=3 → offset=0 next edge and wrap stays 0. Digit 3 (i=3 ≥ L) shows blank.
- restart coinciding with a scroll step → offset=0 and wrap=0. A write to the displayed address mid-slot appears on segments exactly 2 cycles later.
